// File: rtl/ex_div.sv
// ex_div: multi-cycle RV64M divide unit (DIV/DIVU/REM/REMU and W variants).
// Radix-2 restoring divider, one quotient bit per clock. Divide-by-zero and
// signed overflow finish in a single cycle without iterating.
module ex_div #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      waddr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic [4:0]      waddr_o,
    output logic            hold_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sign-extend the low word of a value when w is set, else pass it through.
    function automatic logic [XLEN-1:0] fix_word(input logic [XLEN-1:0] v, input logic w);
        logic [XLEN-1:0] r;
        if (w) begin
            r = {{32{v[31]}}, v[31:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's complement negation when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + 64'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [5:0]      cnt_r;
    logic [XLEN-1:0] rem_r;        // partial remainder
    logic [XLEN-1:0] dvd_r;        // dividend bits still to consume; quotient shifts in at the bottom
    logic [XLEN-1:0] dsr_r;        // divisor magnitude
    logic            neg_q_r;
    logic            neg_r_r;
    logic            sel_rem_r;
    logic            word_r;
    logic [4:0]      waddr_cap_r;
    logic [XLEN-1:0] result_r;
    logic [4:0]      waddr_r;
    logic            valid_r;

    logic            legal_start_s;
    logic            is_signed_s;
    logic [XLEN-1:0] a_ext_s;
    logic [XLEN-1:0] b_ext_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            special_s;
    logic [XLEN-1:0] spec_res_s;

    logic [XLEN:0]   trial_s;
    logic            qbit_s;
    logic [XLEN-1:0] rem_nxt_s;
    logic [XLEN-1:0] dvd_nxt_s;
    logic [XLEN-1:0] calc_res_s;

    // Operand conditioning: truncate/extend W operands, take magnitudes, spot special cases.
    always_comb begin
        legal_start_s = start_i && op_i[2];
        is_signed_s   = !op_i[0];
        if (word_i) begin
            if (is_signed_s) begin
                a_ext_s = {{32{dividend_i[31]}}, dividend_i[31:0]};
                b_ext_s = {{32{divisor_i[31]}},  divisor_i[31:0]};
            end else begin
                a_ext_s = {32'd0, dividend_i[31:0]};
                b_ext_s = {32'd0, divisor_i[31:0]};
            end
        end else begin
            a_ext_s = dividend_i;
            b_ext_s = divisor_i;
        end
        a_neg_s    = is_signed_s && a_ext_s[XLEN-1];
        b_neg_s    = is_signed_s && b_ext_s[XLEN-1];
        a_mag_s    = cond_neg(a_ext_s, a_neg_s);
        b_mag_s    = cond_neg(b_ext_s, b_neg_s);
        div_zero_s = (b_ext_s == 64'd0);
        ovf_s      = is_signed_s && (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF) &&
                     (a_ext_s == (word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special_s  = div_zero_s || ovf_s;
        if (div_zero_s) begin
            spec_res_s = op_i[1] ? a_ext_s : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            spec_res_s = op_i[1] ? 64'd0 : a_ext_s;
        end
        spec_res_s = fix_word(spec_res_s, word_i);
    end

    // One restoring step plus the sign-corrected, selected result of the final step.
    always_comb begin
        trial_s    = {rem_r, dvd_r[XLEN-1]} - {1'b0, dsr_r};
        qbit_s     = !trial_s[XLEN];
        if (qbit_s) begin
            rem_nxt_s = trial_s[XLEN-1:0];
        end else begin
            rem_nxt_s = {rem_r[XLEN-2:0], dvd_r[XLEN-1]};
        end
        dvd_nxt_s  = {dvd_r[XLEN-2:0], qbit_s};
        if (sel_rem_r) begin
            calc_res_s = cond_neg(rem_nxt_s, neg_r_r);
        end else begin
            calc_res_s = cond_neg(dvd_nxt_s, neg_q_r);
        end
        calc_res_s = fix_word(calc_res_s, word_r);
    end

    // Next-state logic and the pipeline stall request.
    always_comb begin
        state_nxt_s = state_r;
        hold_o      = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush_i) begin
                    state_nxt_s = IDLE;
                end else if (legal_start_s) begin
                    hold_o      = 1'b1;
                    state_nxt_s = special_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                hold_o = 1'b1;
                if (flush_i) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == 6'd0) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operation capture, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 6'd0;
            rem_r       <= 64'd0;
            dvd_r       <= 64'd0;
            dsr_r       <= 64'd0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            sel_rem_r   <= 1'b0;
            word_r      <= 1'b0;
            waddr_cap_r <= 5'd0;
            result_r    <= 64'd0;
            waddr_r     <= 5'd0;
            valid_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (legal_start_s && !flush_i) begin
                        sel_rem_r   <= op_i[1];
                        word_r      <= word_i;
                        waddr_cap_r <= waddr_i;
                        neg_q_r     <= a_neg_s ^ b_neg_s;
                        neg_r_r     <= a_neg_s;
                        dsr_r       <= b_mag_s;
                        rem_r       <= 64'd0;
                        // W ops left-align the 32-bit magnitude so the MSB is consumed first.
                        dvd_r       <= word_i ? {a_mag_s[31:0], 32'd0} : a_mag_s;
                        cnt_r       <= word_i ? 6'd31 : 6'd63;
                        if (special_s) begin
                            result_r <= spec_res_s;
                            waddr_r  <= waddr_i;
                            valid_r  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (!flush_i) begin
                        rem_r <= rem_nxt_s;
                        dvd_r <= dvd_nxt_s;
                        if (cnt_r == 6'd0) begin
                            result_r <= calc_res_s;
                            waddr_r  <= waddr_cap_r;
                            valid_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - 6'd1;
                        end
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_r;
    assign waddr_o  = waddr_r;
    assign valid_o  = valid_r;

endmodule

// File: tb/tb_ex_div.sv
// Testbench for ex_div: directed cases plus randomized ops against an arithmetic model.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic        word_i;
    logic [63:0] dividend_i;
    logic [63:0] divisor_i;
    logic [4:0]  waddr_i;
    logic        flush_i;
    logic [63:0] result_o;
    logic        valid_o;
    logic [4:0]  waddr_o;
    logic        hold_o;

    int errors = 0;
    int checks = 0;

    ex_div #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .word_i     (word_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .waddr_i    (waddr_i),
        .flush_i    (flush_i),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .waddr_o    (waddr_o),
        .hold_o     (hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics computed directly with language arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q, r;
        logic        sgn;
        sgn = !op[0];
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            s32 = op[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end else begin
            if (b == 64'd0) begin
                q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a; r = 64'd0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
            end else begin
                q = a / b; r = a % b;
            end
            return op[1] ? r : q;
        end
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic sgn;
        sgn = !op[0];
        if (w) begin
            if (b[31:0] == 32'd0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
                return 1;
            return 33;
        end
        if (b == 64'd0 || (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF))
            return 1;
        return 65;
    endfunction

    // Issue one op at posedge+1 and follow it to its valid pulse.
    // ign_at > 0 pulses a decoy start_i at that cycle after the start edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input int lat, input int ign_at);
        int   cyc;
        logic hold_ok;
        start_i = 1'b1; op_i = op; word_i = w; dividend_i = a; divisor_i = b; waddr_i = rd;
        #1;
        chk({tag, "_hold_start"}, {63'd0, hold_o}, 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        dividend_i = {$urandom, $urandom};
        divisor_i  = {$urandom, $urandom};
        waddr_i    = ~rd;
        cyc = 1;
        hold_ok = 1'b1;
        while (valid_o !== 1'b1 && cyc < 100) begin
            if (hold_o !== 1'b1) hold_ok = 1'b0;
            if (cyc == ign_at) begin
                start_i = 1'b1; op_i = 3'b101; dividend_i = 64'd999; divisor_i = 64'd3;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        chk({tag, "_valid"}, {63'd0, valid_o}, 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_waddr"}, {59'd0, waddr_o}, {59'd0, rd});
        chk({tag, "_hold_calc"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, "_hold_done"}, {63'd0, hold_o}, 64'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_result_hold"}, result_o, exp);
    endtask

    initial begin
        logic [2:0]  rop;
        logic        rw;
        logic [63:0] ra, rb;
        logic        seen;

        rst = 1'b1; start_i = 1'b0; op_i = 3'd0; word_i = 1'b0;
        dividend_i = 64'd0; divisor_i = 64'd0; waddr_i = 5'd0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid",  {63'd0, valid_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_waddr",  {59'd0, waddr_o}, 64'd0);
        chk("rst_hold",   {63'd0, hold_o}, 64'd0);

        // Illegal funct3 (bit2=0) must not start anything.
        start_i = 1'b1; op_i = 3'b000; divisor_i = 64'd3; dividend_i = 64'd9;
        #1 chk("illegal_hold", {63'd0, hold_o}, 64'd0);
        @(posedge clk); #1 start_i = 1'b0;
        chk("illegal_nostart", {63'd0, hold_o | valid_o}, 64'd0);

        run_op("div_100_7",   3'b100, 1'b0, 64'd100, 64'd7, 5'd5, 64'd14, 65, 0);
        run_op("rem_m7_2",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,
               64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("remu_2",      3'b111, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'd1, 65, 0);
        run_op("divu_by0",    3'b101, 1'b0, 64'd123, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("rem_by0",     3'b110, 1'b0, 64'd123, 64'd0, 5'd9, 64'd123, 1, 0);
        run_op("div_ovf",     3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               5'd10, 64'h8000_0000_0000_0000, 1, 0);
        run_op("remw_ovf",    3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               5'd11, 64'd0, 1, 0);
        run_op("divuw_max",   3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd12,
               64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        run_op("divw_garbage", 3'b100, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9,
               5'd13, 64'hFFFF_FFFF_FFFF_FFF2, 33, 0);
        run_op("decoy_start", 3'b100, 1'b0, 64'd1000, 64'd10, 5'd14, 64'd100, 65, 3);

        // Flush in CALC cycle 10 aborts the op.
        start_i = 1'b1; op_i = 3'b100; word_i = 1'b0; dividend_i = 64'd500; divisor_i = 64'd5;
        waddr_i = 5'd15;
        @(posedge clk); #1 start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        chk("flush_hold", {63'd0, hold_o}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) seen = 1'b1;
        end
        chk("flush_novalid", {63'd0, seen}, 64'd0);
        chk("flush_waddr_kept", {59'd0, waddr_o}, {59'd0, 5'd14});
        run_op("after_flush", 3'b110, 1'b0, 64'd500, 64'd7, 5'd16, 64'd3, 65, 0);

        // Flush beats start in IDLE.
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; dividend_i = 64'd8; divisor_i = 64'd2;
        #1 chk("flush_start_hold", {63'd0, hold_o}, 64'd0);
        @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start_idle", {63'd0, hold_o | valid_o}, 64'd0);

        // Reset mid-operation discards it.
        start_i = 1'b1; op_i = 3'b101; word_i = 1'b0; dividend_i = 64'd77; divisor_i = 64'd7;
        waddr_i = 5'd20;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) seen = 1'b1;
        end
        chk("midrst_novalid", {63'd0, seen}, 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_hold", {63'd0, hold_o}, 64'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'(3'd4 + 3'($urandom_range(0, 3)));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = 64'h8000_0000_0000_0000;
                1: ra = {$urandom, 32'h8000_0000};
                2: ra = ra >> $urandom_range(0, 63);
                default: ;
            endcase
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 64'd0;
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: rb = 64'($urandom_range(1, 15));
                3: rb = {$urandom, 32'd0};
                4: rb = rb >> $urandom_range(0, 63);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rop, rw, ra, rb, 5'($urandom_range(0, 31)),
                   model(rop, rw, ra, rb), model_lat(rop, rw, ra, rb), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle RV64M divide unit on the execute side of the decode→execute interface. It accepts operand pairs issued by decode for DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW. It produces the quotient or remainder with the destination register address, and raises a hold request so the pipeline stalls while an iteration is in flight. The datapath is a radix-2 restoring divider: one quotient bit per clock.

## Interface

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  issue request from the execute stage; sampled only in IDLE.
- op_i  in  3  funct3 of the instruction: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Any value with bit2=0 makes start_i ignored.
- word_i  in  1  1 selects a W-variant (opcode 0111011): operate on bits [31:0] only.
- dividend_i  in  XLEN  rs1 operand (forwarded value).
- divisor_i  in  XLEN  rs2 operand (forwarded value).
- waddr_i  in  5  destination register rd.
- flush_i  in  1  pipeline flush (taken branch/jump/trap); aborts the operation.
- result_o  out  XLEN  quotient or remainder. Final value during valid_o.
- valid_o  out  1  one-cycle pulse: result_o/waddr_o are valid, register write required.
- waddr_o  out  5  captured rd.
- hold_o  out  1  stall request to the pipeline controller.

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE:
  - A legal start with flush_i=0 captures op, word, waddr, and operand magnitudes.
  - For a W op, operands are first truncated to [31:0]. Signed W ops are then sign-extended from bit 31.
  - Special case detected → DONE.
  - Otherwise → CALC, with iteration counter = N−1, where N=64 (or 32 if word).
- CALC:
  - One restoring step per cycle: remainder shifts left, takes the next dividend bit, trial-subtracts the divisor, and shifts the quotient bit in.
  - Counter reaches 0 → DONE.
- DONE: valid_o=1 for exactly one cycle, then → IDLE unconditionally.
- Signed ops (DIV, REM, DIVW, REMW):
  - Divide absolute values.
  - Negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Special cases, with results applied before W sign-extension:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^63 ÷ −1, or −2^31 ÷ −1 for W): quotient = dividend; remainder = 0.
- Result selection:
  - REM* selects the remainder, otherwise the quotient.
  - For word ops, result_o = sign-extend(result[31:0]), including DIVUW/REMUW.
- hold_o = (state==IDLE && legal start_i && !flush_i) || state==CALC. hold_o is 0 in DONE, so the pipeline advances with the result.
- start_i while in CALC or DONE: ignored; no effect on the captured operation.
- flush_i in any state:
  - Next state IDLE; valid_o is not asserted for the aborted operation.
  - flush_i beats start_i in the same cycle.
  - flush_i in DONE suppresses nothing already emitted; the pulse in that cycle stands.
- Reset:
  - state=IDLE, counter=0, result_o=0, waddr_o=0, valid_o=0, hold_o=0.
  - Reset mid-operation discards the operation with no valid pulse.
- result_o and waddr_o hold their last values outside DONE.

## Timing

- Edge E0 samples the start.
- Normal op: E1..EN iterate. DONE occupies the cycle after EN, so valid_o goes high N+1 cycles after E0: 65 for 64-bit ops, 33 for W ops.
- Special case: valid_o is high in the cycle immediately after E0, with latency 1.
- hold_o:
  - Rises combinationally in the start cycle.
  - Stays 1 through all CALC cycles.
  - Falls in the DONE cycle.
- A new start_i can be accepted in the cycle after DONE at the earliest. Back-to-back throughput is N+2 cycles.
- All outputs are registered except hold_o, which combines state with start_i/flush_i.

## Test plan

- DIV, 100 ÷ 7, rd=5 → result_o=14 and waddr_o=5 with valid_o in cycle 65 after the start edge. hold_o is high during cycles 0..64.
- REM, −7 ÷ 2 → result_o=0xFFFF_FFFF_FFFF_FFFF (−1). REMU, 0xFFFF_FFFF_FFFF_FFF9 ÷ 2 → 1.
- DIVU by 0, dividend 123 → all ones with latency 1. REM by 0 → 123, with latency 1.
- DIV 0x8000_0000_0000_0000 ÷ −1 → 0x8000_0000_0000_0000, latency 1. REMW 0x8000_0000 ÷ −1 → 0.
- DIVUW 0xFFFF_FFFF ÷ 1 → 0xFFFF_FFFF_FFFF_FFFF, valid at cycle 33. DIVW with upper 32 bits garbage → upper bits ignored.
- flush_i asserted in CALC cycle 10 → no valid_o pulse, hold_o=0 next cycle. A subsequent start then completes normally. A second start_i during CALC is ignored.
